// File: rtl/fb_pkg.sv
// Shared framebuffer geometry for the pixel writer and its word packer.
// Word address layout: {bank, y[7:0], x[7:3]}, 14 bits, bank at bit 13.
package fb_pkg;

  localparam int FB_WIDTH    = 256;
  localparam int FB_HEIGHT   = 240;
  localparam int FB_LANES    = 8;
  localparam int FB_LANE_W   = 3;
  localparam int FB_BYTE_W   = 8;
  localparam int FB_BANK_BIT = 13;
  localparam int FB_WADDR_W  = FB_BANK_BIT + 1;

  // One accepted pixel, already mapped to its word and lane
  typedef struct packed {
    logic [FB_LANE_W-1:0]  lane;
    logic [FB_WADDR_W-1:0] waddr;
    logic [FB_BYTE_W-1:0]  pbyte;
  } fb_pix_t;

  function automatic logic [FB_WADDR_W-1:0] fb_word_addr(input logic       bank,
                                                         input logic [7:0] y,
                                                         input logic [4:0] xw);
    return {bank, y, xw};
  endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// PPU pixel stream in, byte-write RAM port and frame status out.
// master = pixel source / RAM side, slave = fb_pixel_writer.
interface fb_pixel_writer_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 9
);
  logic                        pix_valid;
  logic [5:0]                  color;
  logic [8:0]                  scanline;
  logic [8:0]                  cycle;
  logic [NB_COL-1:0]           we;
  logic [ADDR_WIDTH-1:0]       addr;
  logic [NB_COL*COL_WIDTH-1:0] di;
  logic                        frame_done;
  logic                        disp_bank;

  modport master (
    output pix_valid, color, scanline, cycle,
    input  we, addr, di, frame_done, disp_bank
  );

  modport slave (
    input  pix_valid, color, scanline, cycle,
    output we, addr, di, frame_done, disp_bank
  );
endinterface

// File: rtl/fb_word_packer.sv
// Accumulates pixels into one 8-lane partial word and decides when to flush.
// A flush is issued on the cycle after the triggering pixel (1-cycle latency).
// If a lane-7 pixel lands on a different word than the one held, only one
// write can issue: the old word is flushed and the new pixel is kept as the
// fresh partial word, to be flushed by the next address change.
module fb_word_packer
  import fb_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_accept,
  input  fb_pix_t                       i_pix,
  output logic [FB_LANES-1:0]           o_we,
  output logic [FB_WADDR_W-1:0]         o_addr,
  output logic [FB_LANES*FB_BYTE_W-1:0] o_data
);

  logic [FB_LANES-1:0]           r_mask;
  logic [FB_WADDR_W-1:0]         r_addr;
  logic [FB_LANES*FB_BYTE_W-1:0] r_data;
  logic [FB_LANES-1:0]           r_we;
  logic [FB_WADDR_W-1:0]         r_out_addr;
  logic [FB_LANES*FB_BYTE_W-1:0] r_out_data;

  logic                          w_fresh;
  logic                          w_evict;
  logic                          w_last;
  logic [FB_LANES-1:0]           w_mask;
  logic [FB_LANES*FB_BYTE_W-1:0] w_data;

  // Merge the incoming pixel into the held word (or a fresh one on a new address)
  always_comb begin
    w_fresh = (r_mask == '0) || (r_addr != i_pix.waddr);
    w_evict = i_accept && (r_mask != '0) && (r_addr != i_pix.waddr);
    w_last  = i_accept && (i_pix.lane == FB_LANE_W'(FB_LANES-1));
    w_mask  = w_fresh ? '0 : r_mask;
    w_data  = w_fresh ? '0 : r_data;
    w_mask[i_pix.lane] = 1'b1;
    w_data[i_pix.lane*FB_BYTE_W +: FB_BYTE_W] = i_pix.pbyte;
  end

  // Hold state and registered write port; we defaults to 0 when nothing flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_we <= '0;
      if (i_accept) begin
        r_addr <= i_pix.waddr;
        r_data <= w_data;
        if (w_evict) begin
          r_we       <= r_mask;
          r_out_addr <= r_addr;
          r_out_data <= r_data;
          r_mask     <= w_mask;
        end else if (w_last) begin
          r_we       <= w_mask;
          r_out_addr <= i_pix.waddr;
          r_out_data <= w_data;
          r_mask     <= '0;
        end else begin
          r_mask     <= w_mask;
        end
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_out_addr;
  assign o_data = r_out_data;

endmodule

// File: rtl/fb_pixel_writer.sv
// NES PPU pixel stream to byte-write framebuffer RAM writer.
// Optional FB_DOUBLE_BUFFER_EN: ping-pong between two banks (addr bit 13),
// swapping at end of frame; without it everything lands in bank 0.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 9
)(
  input  logic              clk,
  input  logic              reset,
  fb_pixel_writer_if.slave  bus
);

  logic                          r_bank;
  logic                          r_disp_bank;
  logic                          r_frame_done;

  logic                          w_accept;
  logic                          w_eof;
  fb_pix_t                       w_pix;
  logic [FB_LANES-1:0]           w_pk_we;
  logic [FB_WADDR_W-1:0]         w_pk_addr;
  logic [FB_LANES*FB_BYTE_W-1:0] w_pk_data;
  logic [NB_COL-1:0]             w_we;
  logic [NB_COL*COL_WIDTH-1:0]   w_di;

  // Visible-area filter and pixel-to-word mapping in the current write bank
  always_comb begin
    w_accept    = bus.pix_valid && (bus.scanline < 9'(FB_HEIGHT)) &&
                  (bus.cycle < 9'(FB_WIDTH));
    w_eof       = w_accept && (bus.scanline == 9'(FB_HEIGHT-1)) &&
                  (bus.cycle == 9'(FB_WIDTH-1));
    w_pix.lane  = bus.cycle[2:0];
    w_pix.waddr = fb_word_addr(r_bank, bus.scanline[7:0], bus.cycle[7:3]);
    w_pix.pbyte = {2'b00, bus.color};
  end

  fb_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .i_accept (w_accept),
    .i_pix    (w_pix),
    .o_we     (w_pk_we),
    .o_addr   (w_pk_addr),
    .o_data   (w_pk_data)
  );

`ifdef FB_DOUBLE_BUFFER_EN
  // End of frame publishes the bank just written and switches to the other
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank      <= 1'b0;
      r_disp_bank <= 1'b0;
    end else if (w_eof) begin
      r_disp_bank <= r_bank;
      r_bank      <= ~r_bank;
    end
  end
`else
  // Single-buffered: both bank bits are pinned to 0
  always_ff @(posedge clk) begin
    r_bank      <= 1'b0;
    r_disp_bank <= 1'b0;
  end
`endif

  // frame_done lines up with the flush of the end-of-frame pixel
  always_ff @(posedge clk) begin
    if (reset) r_frame_done <= 1'b0;
    else       r_frame_done <= w_eof;
  end

  // Widen packer output to the RAM geometry; extra columns stay unwritten
  always_comb begin
    w_we = '0;
    w_we[FB_LANES-1:0] = w_pk_we;
    w_di = '0;
    w_di[FB_LANES*FB_BYTE_W-1:0] = w_pk_data;
  end

  assign bus.we         = w_we;
  assign bus.addr       = ADDR_WIDTH'(w_pk_addr);
  assign bus.di         = w_di;
  assign bus.frame_done = r_frame_done;
  assign bus.disp_bank  = r_disp_bank;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer; expectations follow FB_DOUBLE_BUFFER_EN
// when the bench is compiled with that macro defined.
module tb_fb_pixel_writer;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  // Running output totals, sampled mid-cycle
  int   n_wr = 0;
  int   n_fd = 0;
  int   n_b1 = 0;

  fb_pixel_writer_if #(.ADDR_WIDTH(18), .COL_WIDTH(8), .NB_COL(9)) bus();

  fb_pixel_writer #(.ADDR_WIDTH(18), .COL_WIDTH(8), .NB_COL(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.we != '0) begin
      n_wr++;
      if (bus.addr[13]) n_b1++;
    end
    if (bus.frame_done) n_fd++;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic px(input int y, input int x, input int c);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.scanline  = 9'(y);
    bus.cycle     = 9'(x);
    bus.color     = 6'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int wr0, fd0, b10;
    reset         = 1'b1;
    bus.pix_valid = 1'b0;
    bus.scanline  = '0;
    bus.cycle     = '0;
    bus.color     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",   bus.we, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_di",   bus.di, 0);
    chk("rst_fd",   bus.frame_done, 0);
    chk("rst_disp", bus.disp_bank, 0);
    @(negedge clk);
    reset = 1'b0;

    // Eight pixels of one word; colors chosen so di = 0x0007060504030201
    for (int i = 0; i < 7; i++) begin
      px(0, i, i + 1);
      chk("full_partial_we", bus.we, 0);
    end
    px(0, 7, 0);
    chk("full_we",   bus.we, 9'h0FF);
    chk("full_addr", bus.addr, 0);
    chk("full_di",   bus.di, 72'h0007060504030201);

    // Address change evicts partial word; held word proven by its later flush
    idle(1);
    px(0, 0, 6'h11);
    px(0, 1, 6'h12);
    px(0, 2, 6'h13);
    chk("evict_pre_we", bus.we, 0);
    px(0, 16, 6'h15);
    chk("evict_we",   bus.we, 9'h007);
    chk("evict_addr", bus.addr, 0);
    chk("evict_di",   bus.di, 72'h131211);
    px(0, 23, 6'h2A);
    chk("held_we",   bus.we, 9'h081);
    chk("held_addr", bus.addr, 2);
    chk("held_di",   bus.di, 72'h2A00000000000015);

    // Off-screen pixels are ignored (cycle 256 would alias lane 0 if taken)
    px(5, 0, 1);
    px(240, 7, 6'h3F);
    chk("oob_y_we", bus.we, 0);
    px(5, 256, 6'h3F);
    chk("oob_x_we", bus.we, 0);
    px(5, 7, 2);
    chk("oob_we",   bus.we, 9'h081);
    chk("oob_addr", bus.addr, 18'h0A0);
    chk("oob_di",   bus.di, 72'h0200000000000001);

    // Rewriting a lane keeps the last value
    px(1, 8, 5);
    px(1, 8, 9);
    px(1, 15, 3);
    chk("ovw_we",   bus.we, 9'h081);
    chk("ovw_addr", bus.addr, 18'h021);
    chk("ovw_di",   bus.di, 72'h0300000000000009);

    // Reset mid-word drops the partial word
    for (int i = 0; i < 4; i++) px(2, i, 4);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_we",   bus.we, 0);
    chk("mrst_addr", bus.addr, 0);
    chk("mrst_di",   bus.di, 0);
    chk("mrst_fd",   bus.frame_done, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("mrst_idle_we", bus.we, 0);
    px(3, 7, 1);
    chk("mrst_after_we",   bus.we, 9'h080);
    chk("mrst_after_addr", bus.addr, 18'h060);
    chk("mrst_after_di",   bus.di, 72'h0100000000000000);

    // Full frame in bank 0
    idle(2);
    wr0 = n_wr;
    fd0 = n_fd;
    b10 = n_b1;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 256; x++)
        px(y, x, (x ^ y) & 63);
    chk("eof_we",   bus.we, 9'h0FF);
    chk("eof_addr", bus.addr, 18'h1DFF);
    chk("eof_di",   bus.di, 72'h1011121314151617);
    chk("eof_fd",   bus.frame_done, 1);
    idle(2);
    chk("frame_writes", 72'(n_wr - wr0), 7680);
    chk("frame_fd_cnt", 72'(n_fd - fd0), 1);
    chk("frame_fd_off", bus.frame_done, 0);
    chk("frame_disp",   bus.disp_bank, 0);

    // Second frame: first word, then only the last word
    for (int i = 0; i < 8; i++) px(0, i, 0);
`ifdef FB_DOUBLE_BUFFER_EN
    chk("f2_first_addr", bus.addr, 18'h2000);
`else
    chk("f2_first_addr", bus.addr, 18'h0000);
`endif
    for (int i = 248; i < 256; i++) px(239, i, 1);
    chk("f2_eof_fd", bus.frame_done, 1);
`ifdef FB_DOUBLE_BUFFER_EN
    chk("f2_eof_addr", bus.addr, 18'h3DFF);
`else
    chk("f2_eof_addr", bus.addr, 18'h1DFF);
`endif
    idle(2);
    chk("f2_fd_cnt", 72'(n_fd - fd0), 2);
`ifdef FB_DOUBLE_BUFFER_EN
    chk("f2_disp",     bus.disp_bank, 1);
    chk("f2_bank1_wr", 72'(n_b1 - b10), 2);
`else
    chk("f2_disp",     bus.disp_bank, 0);
    chk("f2_bank1_wr", 72'(n_b1 - b10), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
